srd_rst_ack_resp: RTL and testbench
===================================

// Module: srd_rst_ack_resp
// PURPOSE
// Responder end of the SRD reset req/ack handshake: the reset controller drives active-low
// full/TX/RX reset requests and waits for matching active-low acks. This block sits on the
// Ethernet datapath side. Per request it:
// - applies datapath resets for a guaranteed hold time;
// - acks while the request is held;
// - releases the datapath, waits for ready (bounded), then deasserts the ack.
// PARAMETERS
// RST_HOLD_CYC    16    cycles ASSERT holds dp reset before ack (>=1)
// READY_TIMEOUT   1023  max cycles in RELEASE waiting for i_*_ready (>=1)
// SYNC_STAGES     2     synchronizer depth on async request inputs (>=2)
// PORTS
// i_clk            in   1  single clock; all logic here
// i_rst            in   1  synchronous, active-high reset
// i_rst_n          in   1  full reset request, active-low, async (both channels)
// i_tx_rst_n       in   1  TX reset request, active-low, async
// i_rx_rst_n       in   1  RX reset request, active-low, async
// i_tx_ready       in   1  TX datapath ready after release, sync to i_clk
// i_rx_ready       in   1  RX datapath ready after release, sync to i_clk
// o_rst_ack_n      out  1  full reset ack, active-low
// o_tx_rst_ack_n   out  1  TX reset ack, active-low
// o_rx_rst_ack_n   out  1  RX reset ack, active-low
// o_tx_dp_rst      out  1  TX datapath reset, active-high, registered
// o_rx_dp_rst      out  1  RX datapath reset, active-high, registered
// o_timeout        out  2  sticky [1]=RX,[0]=TX ready timeout; cleared only by i_rst
// BEHAVIOUR
// - Requests pass SYNC_STAGES flops. tx_req = ~sync(i_rst_n) | ~sync(i_tx_rst_n); RX likewise.
// - Per-channel FSM; outputs are registered from state.
//   RUN:     dp_rst=0, ack_n=1. Goes to ASSERT when req=1.
//   ASSERT:  dp_rst=1, ack_n=1. Lasts exactly RST_HOLD_CYC cycles (count 0..HOLD-1), then:
//            - goes to ACK if req=1;
//            - goes to RELEASE if req=0 (withdrawn early; no ack pulse).
//   ACK:     dp_rst=1, ack_n=0. Stays while req=1, then goes to RELEASE.
//   RELEASE: dp_rst=0, ack_n=0. Goes to RUN on i_*_ready=1 (checked from the 1st RELEASE cycle).
//            Goes to RUN with o_timeout[ch] set after READY_TIMEOUT cycles without ready.
//            Goes to ASSERT (counter cleared) if req re-asserts; this takes priority over ready.
// - Latency: dp_rst rises SYNC_STAGES+1 clk after the request falling edge.
//   ack_n falls RST_HOLD_CYC clk later. ack_n rises 1 clk after the ready cycle.
// - Full ack:
//   - A register full_pend is set when sync full req=1. It clears when both FSMs are in RUN
//     with full req=0.
//   - o_rst_ack_n=0 iff full_pend and both FSMs are in ACK or RELEASE.
//   - o_rst_ack_n stays 0 until both channels reach RUN, even if one channel finishes first.
// - Full request resets both channels; a simultaneous TX/RX request has no extra effect.
//   A TX-only request never disturbs RX.
// - Counter: one per channel, width $clog2(max(RST_HOLD_CYC,READY_TIMEOUT)+1).
//   Saturates, never wraps. Cleared on every state entry.
// - i_rst=1, in any state:
//   - FSMs go to ASSERT with counter=0.
//   - o_*_dp_rst=1, all ack_n=1, o_timeout=0, full_pend=0, synchronizer flops=1 (no request).
//   - After i_rst falls, ASSERT completes, then the RELEASE path runs (datapath self-resets on
//     power-up with no ack).
// STRUCTURE
// - srd_rst_pkg:
//   - typedef enum logic [1:0] rst_resp_state_e {RUN, ASSERT, ACK, RELEASE};
//   - function cnt_w(hold, tmo).
// - Sub-module srd_rst_resp_fsm (one channel: req, ready -> dp_rst, ack_n, timeout, state),
//   instantiated twice.
// - Request synchronizers: eth_f_altera_std_synchronizer_nocut, three instances.
// - Top level holds only request OR logic, full_pend and o_rst_ack_n.
// TESTING (RST_HOLD_CYC=16, READY_TIMEOUT=64, SYNC_STAGES=2)
// 1. TX 4-phase: i_tx_rst_n low at t0.
//    -> o_tx_dp_rst=1 at t0+3; o_tx_rst_ack_n=0 at t0+19.
//    Release i_tx_rst_n at t1.
//    -> dp_rst=0 at t1+3; ready at t1+10 -> ack_n=1 at t1+11.
//    RX outputs unchanged throughout.
// 2. Full request with RX ready 20 cycles after TX ready.
//    -> o_rst_ack_n=0 after both acks, returns 1 only after RX reaches RUN; o_timeout=0.
// 3. Ready never asserted.
//    -> RELEASE lasts 64 cycles, then ack_n=1, o_timeout=2'b01.
//    Second request -> o_timeout stays 2'b01.
// 4. Request held 5 cycles then withdrawn.
//    -> dp_rst high 16 cycles, ack_n never 0, RUN reached after ready.
// 5. Request re-asserted 3 cycles into RELEASE while ready=1 same cycle.
//    -> ASSERT wins, dp_rst=1 again, full 16-cycle hold, ack again.
// 6. i_rst pulsed while in ACK.
//    -> next cycle ack_n=1, dp_rst=1, o_timeout=0.
//    After i_rst falls with no request -> 16 hold cycles, RELEASE, RUN; no ack pulse.

Source files
------------

// File: rtl/srd_rst_pkg.sv
// Shared types and helpers for the SRD reset-request responder.
package srd_rst_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ASSERT  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } rst_resp_state_e;

  // Counter width that covers both the hold count and the ready timeout.
  function automatic int cnt_w(input int hold, input int tmo);
    int m;
    m = (hold > tmo) ? hold : tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/eth_f_altera_std_synchronizer_nocut.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 (idle for active-low requests).
module eth_f_altera_std_synchronizer_nocut #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], i_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[DEPTH-1];

endmodule

// File: rtl/srd_rst_resp_fsm.sv
// One channel of the reset responder: holds the datapath in reset, acks, then waits for ready.
module srd_rst_resp_fsm
  import srd_rst_pkg::*;
#(
  parameter int RST_HOLD_CYC  = 16,
  parameter int READY_TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic            i_ready,
  output logic            o_dp_rst,
  output logic            o_ack_n,
  output logic            o_timeout,
  output rst_resp_state_e o_state
);

  localparam int CW = cnt_w(RST_HOLD_CYC, READY_TIMEOUT);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(READY_TIMEOUT - 1);

  rst_resp_state_e state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dp_rst_q, dp_rst_d;
  logic            ack_n_q, ack_n_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN:     if (i_req) state_d = ASSERT;
      ASSERT:  if (cnt_q == HOLD_LAST) state_d = i_req ? ACK : RELEASE;
      ACK:     if (!i_req) state_d = RELEASE;
      RELEASE: begin
        // A fresh request beats a same-cycle ready.
        if (i_req) begin
          state_d = ASSERT;
        end else if (i_ready) begin
          state_d = RUN;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ASSERT;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == {CW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    dp_rst_d = (state_d == ASSERT) || (state_d == ACK);

    // RELEASE keeps whatever ack it inherited, so a withdrawn request never pulses the ack.
    case (state_d)
      ACK:     ack_n_d = 1'b0;
      RELEASE: ack_n_d = ack_n_q;
      default: ack_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      dp_rst_q  <= 1'b1;
      ack_n_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dp_rst_q  <= dp_rst_d;
      ack_n_q   <= ack_n_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_dp_rst  = dp_rst_q;
  assign o_ack_n   = ack_n_q;
  assign o_timeout = timeout_q;
  assign o_state   = state_q;

endmodule

// File: rtl/srd_rst_ack_resp.sv
// SRD reset req/ack responder: synchronizes the three requests, runs a TX and an RX
// channel FSM, and produces the combined full-reset ack.
module srd_rst_ack_resp
  import srd_rst_pkg::*;
#(
  parameter int RST_HOLD_CYC  = 16,
  parameter int READY_TIMEOUT = 1023,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rst_n,
  input  logic       i_tx_rst_n,
  input  logic       i_rx_rst_n,
  input  logic       i_tx_ready,
  input  logic       i_rx_ready,
  output logic       o_rst_ack_n,
  output logic       o_tx_rst_ack_n,
  output logic       o_rx_rst_ack_n,
  output logic       o_tx_dp_rst,
  output logic       o_rx_dp_rst,
  output logic [1:0] o_timeout
);

  logic full_n_s, tx_n_s, rx_n_s;
  logic full_req, tx_req, rx_req;
  logic tx_timeout, rx_timeout;
  rst_resp_state_e tx_state, rx_state;
  logic both_run, both_ack;
  logic full_pend_q, full_pend_d;
  logic rst_ack_n_q, rst_ack_n_d;

  eth_f_altera_std_synchronizer_nocut #(.DEPTH(SYNC_STAGES)) u_sync_full (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_rst_n), .o_q(full_n_s)
  );
  eth_f_altera_std_synchronizer_nocut #(.DEPTH(SYNC_STAGES)) u_sync_tx (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_tx_rst_n), .o_q(tx_n_s)
  );
  eth_f_altera_std_synchronizer_nocut #(.DEPTH(SYNC_STAGES)) u_sync_rx (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_rx_rst_n), .o_q(rx_n_s)
  );

  assign full_req = ~full_n_s;
  assign tx_req   = full_req | ~tx_n_s;
  assign rx_req   = full_req | ~rx_n_s;

  srd_rst_resp_fsm #(.RST_HOLD_CYC(RST_HOLD_CYC), .READY_TIMEOUT(READY_TIMEOUT)) u_tx_fsm (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(tx_req), .i_ready(i_tx_ready),
    .o_dp_rst(o_tx_dp_rst), .o_ack_n(o_tx_rst_ack_n), .o_timeout(tx_timeout), .o_state(tx_state)
  );
  srd_rst_resp_fsm #(.RST_HOLD_CYC(RST_HOLD_CYC), .READY_TIMEOUT(READY_TIMEOUT)) u_rx_fsm (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(rx_req), .i_ready(i_rx_ready),
    .o_dp_rst(o_rx_dp_rst), .o_ack_n(o_rx_rst_ack_n), .o_timeout(rx_timeout), .o_state(rx_state)
  );

  assign both_run = (tx_state == RUN) && (rx_state == RUN);
  assign both_ack = ~o_tx_rst_ack_n & ~o_rx_rst_ack_n;

  // The full ack falls once both channels ack and holds until both are back in RUN.
  always_comb begin
    full_pend_d = full_pend_q;
    if (full_req) begin
      full_pend_d = 1'b1;
    end else if (both_run) begin
      full_pend_d = 1'b0;
    end

    rst_ack_n_d = rst_ack_n_q;
    if (full_pend_q && both_ack) begin
      rst_ack_n_d = 1'b0;
    end else if (!full_pend_q || both_run) begin
      rst_ack_n_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_pend_q <= 1'b0;
      rst_ack_n_q <= 1'b1;
    end else begin
      full_pend_q <= full_pend_d;
      rst_ack_n_q <= rst_ack_n_d;
    end
  end

  assign o_rst_ack_n = rst_ack_n_q;
  assign o_timeout   = {rx_timeout, tx_timeout};

endmodule

// File: tb/tb_srd_rst_ack_resp.sv
// Scoreboard bench for srd_rst_ack_resp: each output change is matched against a queued
// {cycle, value} expectation computed by hand from the request timing.
module tb_srd_rst_ack_resp;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_rst_n, i_tx_rst_n, i_rx_rst_n;
  logic       i_tx_ready, i_rx_ready;
  logic       o_rst_ack_n, o_tx_rst_ack_n, o_rx_rst_ack_n;
  logic       o_tx_dp_rst, o_rx_dp_rst;
  logic [1:0] o_timeout;

  srd_rst_ack_resp #(.RST_HOLD_CYC(16), .READY_TIMEOUT(64), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rst_n(i_rst_n), .i_tx_rst_n(i_tx_rst_n), .i_rx_rst_n(i_rx_rst_n),
    .i_tx_ready(i_tx_ready), .i_rx_ready(i_rx_ready),
    .o_rst_ack_n(o_rst_ack_n), .o_tx_rst_ack_n(o_tx_rst_ack_n), .o_rx_rst_ack_n(o_rx_rst_ack_n),
    .o_tx_dp_rst(o_tx_dp_rst), .o_rx_dp_rst(o_rx_dp_rst), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // {full_ack_n, tx_ack_n, rx_ack_n, tx_dp_rst, rx_dp_rst, timeout[1:0]}
  wire [6:0] out_vec = {o_rst_ack_n, o_tx_rst_ack_n, o_rx_rst_ack_n,
                        o_tx_dp_rst, o_rx_dp_rst, o_timeout};

  typedef struct {
    int         cycle;
    logic [6:0] value;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_entry;
  int         check_count = 0;
  int         error_count = 0;
  bit         mon_enable  = 1'b0;
  logic [6:0] prev_out;
  logic [6:0] old_out;
  int         base;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  task automatic expectAt(input int cycle, input logic [6:0] value, input string name);
    exp_t e;
    e.cycle = cycle;
    e.value = value;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic full_n, input logic tx_n, input logic rx_n,
                               input logic tx_rdy, input logic rx_rdy);
    i_rst_n    = full_n;
    i_tx_rst_n = tx_n;
    i_rx_rst_n = rx_n;
    i_tx_ready = tx_rdy;
    i_rx_ready = rx_rdy;
  endtask

  task automatic waitUntil(input int n);
    while (cyc < n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Monitor: every change of the output bundle consumes one expectation.
  always @(negedge i_clk) begin
    if (mon_enable && (out_vec !== prev_out)) begin
      old_out  = prev_out;
      prev_out = out_vec;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_change", 32'(out_vec), 32'(old_out));
      end else begin
        mon_entry = exp_q.pop_front();
        checkOutput({mon_entry.name, ".value"}, 32'(out_vec), 32'(mon_entry.value));
        checkOutput({mon_entry.name, ".cycle"}, 32'(cyc), 32'(mon_entry.cycle));
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    applyStimulus(1, 1, 1, 1, 1);
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("reset_state", 32'(out_vec), 32'(7'b1111100));
    prev_out   = out_vec;
    mon_enable = 1'b1;

    // Power-up: hold completes, release with no ack.
    base  = cyc;
    i_rst = 1'b0;
    expectAt(base + 16, 7'b1110000, "pwrup.release");
    waitUntil(base + 18);
    applyStimulus(1, 1, 1, 0, 0);

    // TX 4-phase handshake.
    waitUntil(cyc + 4);
    base = cyc;
    applyStimulus(1, 0, 1, 0, 0);
    expectAt(base + 3,  7'b1111000, "t1.dp_on");
    expectAt(base + 19, 7'b1011000, "t1.ack");
    waitUntil(base + 25);
    base = cyc;
    applyStimulus(1, 1, 1, 0, 0);
    expectAt(base + 3,  7'b1010000, "t1.dp_off");
    expectAt(base + 11, 7'b1110000, "t1.ack_off");
    waitUntil(base + 10);
    applyStimulus(1, 1, 1, 1, 0);
    waitUntil(base + 12);
    applyStimulus(1, 1, 1, 0, 0);

    // Full request, RX ready 20 cycles after TX ready.
    waitUntil(cyc + 4);
    base = cyc;
    applyStimulus(0, 1, 1, 0, 0);
    expectAt(base + 3,  7'b1111100, "t2.dp_on");
    expectAt(base + 19, 7'b1001100, "t2.ch_ack");
    expectAt(base + 20, 7'b0001100, "t2.full_ack");
    waitUntil(base + 30);
    base = cyc;
    applyStimulus(1, 1, 1, 0, 0);
    expectAt(base + 3,  7'b0000000, "t2.dp_off");
    expectAt(base + 11, 7'b0100000, "t2.tx_done");
    expectAt(base + 31, 7'b0110000, "t2.rx_done");
    expectAt(base + 32, 7'b1110000, "t2.full_done");
    waitUntil(base + 10);
    applyStimulus(1, 1, 1, 1, 0);
    waitUntil(base + 30);
    applyStimulus(1, 1, 1, 1, 1);
    waitUntil(base + 35);
    applyStimulus(1, 1, 1, 0, 0);

    // TX ready never arrives: timeout, then a second request keeps the sticky flag.
    waitUntil(cyc + 4);
    base = cyc;
    applyStimulus(1, 0, 1, 0, 0);
    expectAt(base + 3,  7'b1111000, "t3.dp_on");
    expectAt(base + 19, 7'b1011000, "t3.ack");
    waitUntil(base + 22);
    base = cyc;
    applyStimulus(1, 1, 1, 0, 0);
    expectAt(base + 3,  7'b1010000, "t3.dp_off");
    expectAt(base + 67, 7'b1110001, "t3.timeout");
    waitUntil(base + 70);
    base = cyc;
    applyStimulus(1, 0, 1, 0, 0);
    expectAt(base + 3,  7'b1111001, "t3b.dp_on");
    expectAt(base + 19, 7'b1011001, "t3b.ack");
    waitUntil(base + 22);
    base = cyc;
    applyStimulus(1, 1, 1, 0, 0);
    expectAt(base + 3, 7'b1010001, "t3b.dp_off");
    expectAt(base + 6, 7'b1110001, "t3b.ack_off");
    waitUntil(base + 5);
    applyStimulus(1, 1, 1, 1, 0);
    waitUntil(base + 7);
    applyStimulus(1, 1, 1, 0, 0);

    // RX request withdrawn after 5 cycles: full hold, no ack.
    waitUntil(cyc + 4);
    base = cyc;
    applyStimulus(1, 1, 0, 0, 0);
    expectAt(base + 3,  7'b1110101, "t4.dp_on");
    expectAt(base + 19, 7'b1110001, "t4.dp_off");
    waitUntil(base + 5);
    applyStimulus(1, 1, 1, 0, 0);
    waitUntil(base + 25);
    applyStimulus(1, 1, 1, 0, 1);
    waitUntil(base + 27);
    applyStimulus(1, 1, 1, 0, 0);

    // TX re-request lands with ready in the same RELEASE cycle: ASSERT wins.
    waitUntil(cyc + 4);
    base = cyc;
    applyStimulus(1, 0, 1, 0, 0);
    expectAt(base + 3,  7'b1111001, "t5.dp_on");
    expectAt(base + 19, 7'b1011001, "t5.ack");
    waitUntil(base + 22);
    base = cyc;
    applyStimulus(1, 1, 1, 0, 0);
    expectAt(base + 3,  7'b1010001, "t5.release");
    expectAt(base + 6,  7'b1111001, "t5.reassert");
    expectAt(base + 22, 7'b1011001, "t5.reack");
    waitUntil(base + 3);
    applyStimulus(1, 0, 1, 0, 0);
    waitUntil(base + 5);
    applyStimulus(1, 0, 1, 1, 0);
    waitUntil(base + 7);
    applyStimulus(1, 0, 1, 0, 0);
    waitUntil(base + 30);
    base = cyc;
    applyStimulus(1, 1, 1, 0, 0);
    expectAt(base + 3, 7'b1010001, "t5.dp_off");
    expectAt(base + 5, 7'b1110001, "t5.ack_off");
    waitUntil(base + 4);
    applyStimulus(1, 1, 1, 1, 0);
    waitUntil(base + 6);
    applyStimulus(1, 1, 1, 0, 0);

    // Synchronous reset pulse during a full-reset ACK.
    waitUntil(cyc + 4);
    base = cyc;
    applyStimulus(0, 1, 1, 0, 0);
    expectAt(base + 3,  7'b1111101, "t6.dp_on");
    expectAt(base + 19, 7'b1001101, "t6.ch_ack");
    expectAt(base + 20, 7'b0001101, "t6.full_ack");
    waitUntil(base + 25);
    applyStimulus(1, 1, 1, 0, 0);
    i_rst = 1'b1;
    expectAt(base + 26, 7'b1111100, "t6.reset");
    waitUntil(base + 26);
    i_rst = 1'b0;
    expectAt(base + 42, 7'b1110000, "t6.self_release");
    waitUntil(base + 30);
    applyStimulus(1, 1, 1, 1, 1);
    waitUntil(base + 60);

    checkOutput("leftover_expects", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
